// File: rtl/gpio_peripheral_multi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_multi_pkg : register offsets and bus width for the multi-port GPIO
// Revision 1.0
// ---------------------------------------------------------------------------
package gpio_multi_pkg;

  localparam int unsigned BUS_W = 64;

  localparam logic [4:0] OFF_DATA   = 5'd0;
  localparam logic [4:0] OFF_DIR    = 5'd8;
  localparam logic [4:0] OFF_STATUS = 5'd16;
  localparam logic [4:0] OFF_IRQ_EN = 5'd24;

endpackage : gpio_multi_pkg
`default_nettype wire

// File: rtl/gpio_peripheral_multi_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_port : one GPIO port (registers, synchroniser, debouncer, edge capture)
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_port
  import gpio_multi_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             sel_i,
  input  logic [4:0]       off_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] pin_out_o,
  output logic [WIDTH-1:0] pin_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] out_q,    out_d;
  logic [WIDTH-1:0] dir_q,    dir_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] sync1_q,  sync1_d;
  logic [WIDTH-1:0] sync2_q,  sync2_d;
  logic [WIDTH-1:0] samp_q,   samp_d;
  logic [WIDTH-1:0] deb_q,    deb_d;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] w1c;
  logic             wr_hit;

  always_comb begin
    wr_hit   = wr_i && sel_i;
    out_d    = out_q;
    dir_d    = dir_q;
    irq_en_d = irq_en_q;
    w1c      = '0;
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    samp_d   = samp_q;
    deb_d    = deb_q;
    stable   = ~(sync2_q ^ samp_q);

    if (wr_hit) begin
      case (off_i)
        OFF_DATA:   out_d    = wdata_i;
        OFF_DIR:    dir_d    = wdata_i;
        OFF_STATUS: w1c      = wdata_i;
        OFF_IRQ_EN: irq_en_d = wdata_i;
        default:    ;
      endcase
    end

    // A level is accepted only when two consecutive ticks agree
    if (tick_i) begin
      samp_d = sync2_q;
      deb_d  = (stable & sync2_q) | (~stable & deb_q);
    end

    status_d = (status_q & ~w1c) | (deb_d & ~deb_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      dir_q    <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      deb_q    <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      samp_q   <= samp_d;
      deb_q    <= deb_d;
    end
  end

  always_comb begin
    case (off_i)
      OFF_DATA:   rdata_o = (dir_q & out_q) | (~dir_q & deb_q);
      OFF_DIR:    rdata_o = dir_q;
      OFF_STATUS: rdata_o = status_q;
      OFF_IRQ_EN: rdata_o = irq_en_q;
      default:    rdata_o = '0;
    endcase
  end

  assign pin_out_o = out_q;
  assign pin_oe_o  = dir_q;
  assign irq_o     = |(status_q & irq_en_q);

endmodule : gpio_port
`default_nettype wire

// File: rtl/gpio_peripheral_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_peripheral_multi : NUM_PORTS memory-mapped GPIO ports on a tri-state bus
// Revision 1.0
// ---------------------------------------------------------------------------
module gpio_peripheral_multi
  import gpio_multi_pkg::*;
#(
  parameter int          NUM_PORTS    = 2,
  parameter int          PORT_WIDTH   = 20,
  parameter logic [63:0] BASE_ADDR    = 64'h400,
  parameter int          STRIDE       = 32,
  parameter int          DEBOUNCE_DIV = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  inout  wire [NUM_PORTS*PORT_WIDTH-1:0]   pins,
  inout  wire [BUS_W-1:0]                  data,
  input  logic [63:0]                      address,
  input  logic                             read,
  input  logic                             write,
  output logic                             irq
);

  localparam int NPINS   = NUM_PORTS * PORT_WIDTH;
  localparam int PRESC_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  tick;
  logic [NUM_PORTS-1:0]  sel;
  logic [NUM_PORTS-1:0]  port_irq;
  logic [PORT_WIDTH-1:0] port_rdata [NUM_PORTS];
  logic [PORT_WIDTH-1:0] rd_sel;
  logic [NPINS-1:0]      pin_out;
  logic [NPINS-1:0]      pin_oe;
  logic                  hit;
  logic                  irq_q, irq_d;

  assign tick    = (presc_q == PRESC_W'(DEBOUNCE_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      irq_q   <= irq_d;
    end
  end

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [63:0] rel;
      // Only offsets 0/8/16/24 inside the port's own window decode as a hit
      assign rel    = address - (BASE_ADDR + 64'(p * STRIDE));
      assign sel[p] = (rel[63:5] == '0) && (rel[2:0] == 3'b000) && (rel < 64'(STRIDE));

      gpio_port #(
        .WIDTH (PORT_WIDTH)
      ) u_port (
        .clk_i     (clock),
        .rst_i     (reset),
        .tick_i    (tick),
        .sel_i     (sel[p]),
        .off_i     (rel[4:0]),
        .wr_i      (write),
        .wdata_i   (data[PORT_WIDTH-1:0]),
        .pin_i     (pins[p*PORT_WIDTH +: PORT_WIDTH]),
        .rdata_o   (port_rdata[p]),
        .pin_out_o (pin_out[p*PORT_WIDTH +: PORT_WIDTH]),
        .pin_oe_o  (pin_oe[p*PORT_WIDTH +: PORT_WIDTH]),
        .irq_o     (port_irq[p])
      );
    end

    for (genvar b = 0; b < NPINS; b++) begin : g_pin
      assign pins[b] = pin_oe[b] ? pin_out[b] : 1'bz;
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel[p]) rd_sel = rd_sel | port_rdata[p];
    end
  end

  assign hit   = |sel;
  assign data  = (read && hit) ? BUS_W'(rd_sel) : {BUS_W{1'bz}};
  assign irq_d = |port_irq;
  assign irq   = irq_q;

endmodule : gpio_peripheral_multi
`default_nettype wire

// File: tb/tb_gpio_peripheral_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_peripheral_multi : self-checking bench for gpio_peripheral_multi
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_gpio_peripheral_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        irq;
  logic [63:0] data_val = '0;
  logic        data_oe = 1'b0;
  logic [39:0] pin_val = '0;
  logic [39:0] pin_oe = '1;
  wire  [39:0] pins;
  wire  [63:0] data;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        is_wr;
    logic [63:0] addr;
    logic [63:0] val;
    string       name;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  assign data = data_oe ? data_val : 64'bz;
  for (genvar k = 0; k < 40; k++) begin : g_tbpin
    assign pins[k] = pin_oe[k] ? pin_val[k] : 1'bz;
  end

  gpio_peripheral_multi dut (
    .clock   (clk),
    .reset   (rst),
    .pins    (pins),
    .data    (data),
    .address (address),
    .read    (read),
    .write   (write),
    .irq     (irq)
  );

  function automatic logic [63:0] high_mask(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (v[i] === 1'b1);
    return r;
  endfunction

  task automatic sb_push(input string n, input logic [63:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic sb_check(input logic [63:0] act);
    exp_t x;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation", act);
    end else begin
      x = sb_q.pop_front();
      if (act !== x.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic bus_write(input logic [63:0] a, input logic [63:0] v);
    @(negedge clk);
    address  = a;
    data_val = v;
    data_oe  = 1'b1;
    write    = 1'b1;
    @(negedge clk);
    write    = 1'b0;
    data_oe  = 1'b0;
    address  = '0;
  endtask

  task automatic bus_read(input logic [63:0] a, input logic [63:0] e, input string n);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    sb_push(n, e);
    #1;
    sb_check(data);
    read    = 1'b0;
    address = '0;
  endtask

  // Checks that the bus is left floating: no bit may read as a driven 1
  task automatic bus_read_z(input logic [63:0] a, input string n);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    sb_push(n, 64'h0);
    #1;
    sb_check(high_mask(data));
    read    = 1'b0;
    address = '0;
  endtask

  task automatic raw_read(input logic [63:0] a, output logic [63:0] v);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    #1;
    v       = data;
    read    = 1'b0;
    address = '0;
  endtask

  task automatic check_val(input string n, input logic [63:0] act, input logic [63:0] e);
    sb_push(n, e);
    sb_check(act);
  endtask

  initial begin
    logic [63:0] v;
    int          seen;
    int          guard;

    vecs[0] = '{1'b1, 64'h408, 64'h00000000000FFFFF, "wr_dir0"};
    vecs[1] = '{1'b1, 64'h400, 64'hFFFFFFFFFFF0A5A5, "wr_data0"};
    vecs[2] = '{1'b0, 64'h408, 64'h00000000000FFFFF, "rd_dir0"};
    vecs[3] = '{1'b0, 64'h400, 64'h000000000000A5A5, "rd_data0_out"};
    vecs[4] = '{1'b0, 64'h438, 64'h0000000000000000, "rd_irqen1_reset"};
    vecs[5] = '{1'b0, 64'h428, 64'h0000000000000000, "rd_dir1_reset"};

    pin_val = '0;
    pin_oe  = '0;
    repeat (3) @(negedge clk);
    check_val("irq_in_reset", 64'(irq), 64'h0);
    check_val("pins_z_in_reset", high_mask(64'(pins)), 64'h0);
    pin_oe = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_val("irq_after_reset", 64'(irq), 64'h0);
    bus_read(64'h400, 64'h0, "rd_data0_reset");

    // Port 0 becomes an output port; stop driving it from the bench
    pin_oe[19:0] = '0;
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].val);
      else               bus_read(vecs[i].addr, vecs[i].val, vecs[i].name);
    end
    @(negedge clk);
    check_val("pins0_driven", 64'(pins[19:0]), 64'h0A5A5);
    pin_oe[39:20] = '0;
    #1;
    check_val("pins1_z", high_mask(64'(pins[39:20])), 64'h0);
    pin_val[39:20] = '0;
    pin_oe[39:20]  = '1;
    repeat (16) @(negedge clk);

    // Port 1 bit 3 rising edge through sync + debounce
    pin_val[23] = 1'b1;
    seen  = 0;
    guard = 0;
    while (seen == 0 && guard < 20) begin
      guard++;
      raw_read(64'h430, v);
      if (v == 64'h8) seen = guard;
    end
    check_val("p1b3_deb_latency_7to10", 64'((seen >= 7) && (seen <= 10)), 64'h1);
    bus_read(64'h430, 64'h8, "rd_status1_b3");
    check_val("irq_masked", 64'(irq), 64'h0);
    bus_write(64'h438, 64'h8);
    check_val("irq_one_cycle_late", 64'(irq), 64'h0);
    @(negedge clk);
    check_val("irq_enabled", 64'(irq), 64'h1);

    // Glitch on port 0 bit 0
    bus_write(64'h408, 64'hFFFFE);
    pin_val[0] = 1'b0;
    pin_oe[0]  = 1'b1;
    repeat (16) @(negedge clk);
    bus_write(64'h410, 64'hFFFFF);
    bus_read(64'h410, 64'h0, "rd_status0_cleared");
    @(negedge clk);
    pin_val[0] = 1'b1;
    repeat (2) @(negedge clk);
    pin_val[0] = 1'b0;
    repeat (16) @(negedge clk);
    bus_read(64'h410, 64'h0, "glitch_status0");
    bus_read(64'h400, 64'hA5A4, "glitch_data0");

    // Clear while high, then a falling edge must not set status
    bus_write(64'h430, 64'h8);
    check_val("irq_hold_after_w1c", 64'(irq), 64'h1);
    @(negedge clk);
    check_val("irq_drop_after_w1c", 64'(irq), 64'h0);
    bus_read(64'h430, 64'h0, "rd_status1_w1c");
    pin_val[23] = 1'b0;
    repeat (16) @(negedge clk);
    bus_read(64'h430, 64'h0, "fall_not_captured");

    // Align the rising edge to the prescaler so W1C lands on the set edge
    guard = 0;
    @(negedge clk);
    while ((cyc % 4) != 1 && guard < 8) begin
      guard++;
      @(negedge clk);
    end
    pin_val[23] = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(64'h430, 64'h8);
    bus_read(64'h430, 64'h8, "set_beats_w1c");
    check_val("irq_after_collision", 64'(irq), 64'h1);
    bus_write(64'h430, 64'h8);
    bus_read(64'h430, 64'h0, "later_w1c_clears");
    check_val("irq_dropped_again", 64'(irq), 64'h0);

    // Non-hit accesses
    bus_read_z(64'h404, "rd_misaligned_z");
    bus_read_z(64'h440, "rd_outside_z");
    bus_read_z(64'h3F8, "rd_below_z");
    bus_write(64'h404, 64'hFFFFF);
    bus_write(64'h440, 64'hFFFFF);
    bus_write(64'h40C, 64'h0);
    bus_read(64'h400, 64'hA5A4, "data0_after_nohit_wr");
    bus_read(64'h408, 64'hFFFFE, "dir0_after_nohit_wr");

    // Reset asserted between clock edges, in the middle of a write
    bus_write(64'h438, 64'h8);
    @(negedge clk);
    address  = 64'h408;
    data_val = 64'h3;
    data_oe  = 1'b1;
    write    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_val("pins_z_on_async_reset", high_mask(64'(pins)) & ~64'(pin_oe), 64'h0);
    check_val("irq_on_async_reset", 64'(irq), 64'h0);
    @(negedge clk);
    write   = 1'b0;
    data_oe = 1'b0;
    address = '0;
    rst     = 1'b0;
    bus_read(64'h408, 64'h0, "dir0_after_reset");
    bus_read(64'h430, 64'h0, "status1_after_reset");
    bus_read(64'h438, 64'h0, "irqen1_after_reset");
    bus_read(64'h400, 64'h0, "data0_after_reset");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_gpio_peripheral_multi
`default_nettype wire
